// File: rtl/led_pattern_seq.sv
// led_pattern_seq: eight-LED pattern sequencer with optional PWM dimming.
//
// An 8-bit pattern register advances once per tick strobe, following one of
// four patterns chosen by the latched mode:
//   PASS   (00) pattern follows din
//   SHIFT  (01) a single lit LED rotates left
//   BOUNCE (10) a single lit LED sweeps left to 0x80 and back to 0x01
//   FILL   (11) LEDs fill from bit 0 up to 0xFF, then clear (9-step cycle)
// A change of mode takes effect on the next tick, which loads the new mode's
// start pattern. frame pulses for one cycle after each pattern wrap.
//
// Optional feature macro: LED_PWM_EN
//   defined   - a free-running PWM_BITS-bit counter gates led, giving a
//               duty of (bright+1)/2^PWM_BITS
//   undefined - no PWM counter; bright is ignored and led follows pattern
//
// Parameters:
//   PWM_BITS  width of the PWM counter and of bright (default 3)
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   tick      single-cycle step strobe
//   din       value shown in PASS mode
//   mode      pattern select
//   bright    brightness level (used only with LED_PWM_EN)
//   led       registered LED drive, one cycle behind the pattern register
//   frame     single-cycle pulse after a pattern wrap

module led_pattern_seq #(
   parameter int unsigned PWM_BITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic [7:0]          din,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] bright,
   output logic [7:0]          led,
   output logic                frame
);

   typedef enum logic [1:0] {
      ModePass   = 2'b00,
      ModeShift  = 2'b01,
      ModeBounce = 2'b10,
      ModeFill   = 2'b11
   } mode_e;

   // Sweep direction for BOUNCE
   typedef enum logic {
      StLeft,
      StRight
   } dir_e;

   logic [7:0] pattern_q, pattern_d;
   mode_e      mode_q, mode_d;
   mode_e      mode_in;
   dir_e       dir_q, dir_d;
   logic       frame_d;
   logic [7:0] led_d;

   assign mode_in = mode_e'(mode);

   // Next-state logic: everything holds unless tick is high.
   always_comb begin
      pattern_d = pattern_q;
      mode_d    = mode_q;
      dir_d     = dir_q;
      frame_d   = 1'b0;
      if (tick) begin
         if (mode_in != mode_q) begin
            // Mode change: load the start pattern; never a wrap.
            mode_d = mode_in;
            dir_d  = StLeft;
            unique case (mode_in)
               ModePass:   pattern_d = din;
               ModeShift:  pattern_d = 8'h01;
               ModeBounce: pattern_d = 8'h01;
               ModeFill:   pattern_d = 8'h00;
               default:    pattern_d = 8'h00;
            endcase
         end else begin
            unique case (mode_q)
               ModePass: begin
                  pattern_d = din;
               end
               ModeShift: begin
                  pattern_d = {pattern_q[6:0], pattern_q[7]};
                  frame_d   = (pattern_q == 8'h80);
               end
               ModeBounce: begin
                  if (dir_q == StLeft) begin
                     pattern_d = {pattern_q[6:0], 1'b0};
                     // Turn around as soon as the top is reached so 0x80
                     // is shown only once.
                     if (pattern_d == 8'h80) begin
                        dir_d = StRight;
                     end
                  end else begin
                     pattern_d = {1'b0, pattern_q[7:1]};
                     if (pattern_d == 8'h01) begin
                        dir_d   = StLeft;
                        frame_d = 1'b1;
                     end
                  end
               end
               ModeFill: begin
                  if (pattern_q == 8'hFF) begin
                     pattern_d = 8'h00;
                     frame_d   = 1'b1;
                  end else begin
                     pattern_d = {pattern_q[6:0], 1'b1};
                  end
               end
               default: begin
                  pattern_d = pattern_q;
               end
            endcase
         end
      end
   end

`ifdef LED_PWM_EN
   logic [PWM_BITS-1:0] pwm_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
   end

   // On for counts 0..bright, i.e. bright+1 of every 2^PWM_BITS cycles.
   assign led_d = pattern_q & {8{pwm_cnt_q <= bright}};
`else
   logic unused_bright;
   assign unused_bright = ^bright;
   assign led_d         = pattern_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q <= 8'h00;
         mode_q    <= ModePass;
         dir_q     <= StLeft;
         led       <= 8'h00;
         frame     <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         led       <= led_d;
         frame     <= frame_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq: directed sequences followed by randomized
// stimulus. The driver pushes the expected led/frame for every clock edge into
// a queue; an independent monitor pops and compares one cycle later.
// Honours LED_PWM_EN the same way as the design.

module tb_led_pattern_seq;

   localparam int unsigned PWM_BITS = 3;

   logic                clk;
   logic                rst;
   logic                tick;
   logic [7:0]          din;
   logic [1:0]          mode;
   logic [PWM_BITS-1:0] bright;
   logic [7:0]          led;
   logic                frame;

   led_pattern_seq #(
      .PWM_BITS(PWM_BITS)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .din   (din),
      .mode  (mode),
      .bright(bright),
      .led   (led),
      .frame (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] led;
      logic       frame;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state: pattern as a position in its cycle.
   int         m_mode;
   int         m_idx;
   int         m_pwm;
   logic [7:0] m_pat;

   // Pattern at position k of a mode's cycle.
   function automatic logic [7:0] pat_of(input int md, input int k);
      logic [8:0] f;
      case (md)
         1: return 8'h01 << k;
         2: return (k <= 7) ? (8'h01 << k) : (8'h01 << (14 - k));
         3: begin
            f = (9'h001 << k) - 9'h001;
            return f[7:0];
         end
         default: return 8'h00;
      endcase
   endfunction

   function automatic int cycle_len(input int md);
      case (md)
         1: return 8;
         2: return 14;
         default: return 9;
      endcase
   endfunction

   function automatic logic [7:0] pwm_mask(input int cnt, input int b);
`ifdef LED_PWM_EN
      return (cnt <= b) ? 8'hFF : 8'h00;
`else
      return 8'hFF;
`endif
   endfunction

   // Drive one cycle of inputs and queue the response due after the next edge.
   task automatic step(input bit r, input bit t, input int md, input logic [7:0] d,
                       input int b);
      exp_t e;
      @(negedge clk);
      rst    = r;
      tick   = t;
      mode   = 2'(md);
      din    = d;
      bright = PWM_BITS'(b);
      e.frame = 1'b0;
      if (r) begin
         e.led  = 8'h00;
         m_pat  = 8'h00;
         m_mode = 0;
         m_idx  = 0;
         m_pwm  = 0;
      end else begin
         e.led = m_pat & pwm_mask(m_pwm, b);
         m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
         if (t) begin
            if (md != m_mode) begin
               m_mode = md;
               m_idx  = 0;
               m_pat  = (md == 0) ? d : pat_of(md, 0);
            end else if (m_mode == 0) begin
               m_pat = d;
            end else begin
               m_idx   = (m_idx + 1) % cycle_len(m_mode);
               m_pat   = pat_of(m_mode, m_idx);
               e.frame = (m_idx == 0);
            end
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle is an output cycle for this block.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (led !== e.led) begin
               n_err++;
               $display("FAIL led at %0t: got %02h expected %02h", $time, led, e.led);
            end
            n_vec++;
            if (frame !== e.frame) begin
               n_err++;
               $display("FAIL frame at %0t: got %0b expected %0b", $time, frame, e.frame);
            end
         end
      end
   end

   initial begin
      int md;
      rst    = 1'b1;
      tick   = 1'b0;
      mode   = 2'b00;
      din    = 8'h00;
      bright = '1;
      m_mode = 0;
      m_idx  = 0;
      m_pwm  = 0;
      m_pat  = 8'h00;

      // Reset for two cycles
      step(1, 0, 0, 8'h00, 7);
      step(1, 0, 0, 8'h00, 7);

      // SHIFT: load plus 8 ticks, ticks separated by idle cycles
      for (int i = 0; i < 9; i++) begin
         step(0, 1, 1, 8'h00, 7);
         step(0, 0, 1, 8'h00, 7);
      end
      step(0, 0, 1, 8'h00, 7);

      // BOUNCE: load plus 16 back-to-back ticks
      for (int i = 0; i < 17; i++) step(0, 1, 2, 8'h00, 7);
      step(0, 0, 2, 8'h00, 7);

      // FILL: load plus 9 ticks
      for (int i = 0; i < 10; i++) step(0, 1, 3, 8'h00, 7);
      step(0, 0, 3, 8'h00, 7);

      // PASS with dimming levels 1 and 7
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'hA5, 1);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'hA5, 7);

      // SHIFT to 0x10, then reset together with tick
      for (int i = 0; i < 5; i++) step(0, 1, 1, 8'h00, 7);
      step(1, 1, 1, 8'h00, 7);
      step(0, 0, 1, 8'h00, 7);
      step(0, 0, 1, 8'h00, 7);

      // Mode change with tick low is ignored until the next tick
      for (int i = 0; i < 4; i++) step(0, 1, 1, 8'h00, 7);
      for (int i = 0; i < 20; i++) step(0, 0, 3, 8'($urandom), 7);
      step(0, 1, 3, 8'h00, 7);
      step(0, 0, 3, 8'h00, 7);

      // Randomized phase; mode is sticky so patterns run through their wraps
      md = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
         step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), md,
              8'($urandom), $urandom_range(0, 7));
      end
      step(0, 0, md, 8'h00, 7);

      repeat (3) @(posedge clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
